block_b_cp_scheduler: RTL

- Shares block_b's single control_plane_out channel between NUM_REQ control-plane requesters.
- Uses round-robin arbitration with optional locked bursts.
- Widens each 10-bit request address to the 21-bit output address space by prepending a per-requester programmable base.
- Sits between the control_plane_in sources and the control_plane_out BFM-facing port in the block_b testbench DUT.

---
 rtl/block_b_cp_sched_pkg.sv | 32 +++
 rtl/block_b_rr_arbiter.sv | 30 +++
 rtl/block_b_cp_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/block_b_cp_sched_pkg.sv
// Shared widths, state encoding and output beat layout for the control-plane scheduler.
package block_b_cp_sched_pkg;

    localparam int unsigned DEF_NUM_REQ       = 4;
    localparam int unsigned DEF_MAX_BURST     = 4;
    localparam int unsigned CP_IN_ADDR_WIDTH  = 10;
    localparam int unsigned CP_OUT_ADDR_WIDTH = 21;
    localparam int unsigned CP_DATA_WIDTH     = 20;
    localparam int unsigned BASE_WIDTH        = CP_OUT_ADDR_WIDTH - CP_IN_ADDR_WIDTH;
    localparam int unsigned SRC_WIDTH         = $clog2(DEF_NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        BURST = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [CP_OUT_ADDR_WIDTH-1:0] addr;
        logic [CP_DATA_WIDTH-1:0]     data;
        logic [SRC_WIDTH-1:0]         src;
    } cp_beat_t;

    // Output address is the requester base prepended to its local address.
    function automatic logic [CP_OUT_ADDR_WIDTH-1:0] widen_addr(
        input logic [BASE_WIDTH-1:0]       base,
        input logic [CP_IN_ADDR_WIDTH-1:0] addr
    );
        return {base, addr};
    endfunction

endpackage

// File: rtl/block_b_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap.
module block_b_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    // Walk the requesters starting at ptr and take the first valid one.
    always_comb begin
        logic [IDX_W-1:0] cand;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!any_grant && req[cand]) begin
                any_grant       = 1'b1;
                grant_idx       = cand;
                grant[cand]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/block_b_cp_scheduler.sv
// Shares the single control_plane_out channel between requesters with
// round-robin arbitration, capped locked bursts and per-requester address bases.
module block_b_cp_scheduler
    import block_b_cp_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ-1:0]                    req_lock,
    input  logic [NUM_REQ*CP_IN_ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*CP_DATA_WIDTH-1:0]      req_data,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic                                  cfg_we,
    input  logic [$clog2(NUM_REQ)-1:0]            cfg_idx,
    input  logic [BASE_WIDTH-1:0]                 cfg_base,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [CP_OUT_ADDR_WIDTH-1:0]          out_addr,
    output logic [CP_DATA_WIDTH-1:0]              out_data,
    output logic [$clog2(NUM_REQ)-1:0]            out_src,
    output logic                                  busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    sched_state_t                state;
    cp_beat_t                    beat;
    logic [IDX_W-1:0]            ptr;
    logic [CNT_W-1:0]            burst_cnt;
    logic [BASE_WIDTH-1:0]       base [NUM_REQ];

    logic [CP_IN_ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [CP_DATA_WIDTH-1:0]    data_arr [NUM_REQ];

    logic [NUM_REQ-1:0]          arb_grant;
    logic [IDX_W-1:0]            arb_idx;
    logic                        arb_any;

    logic                        load;
    logic                        cont;
    logic                        sel_any;
    logic [IDX_W-1:0]            sel_idx;
    logic [NUM_REQ-1:0]          grant_onehot;
    logic [CNT_W-1:0]            next_cnt;
    logic [IDX_W-1:0]            owner;

    assign owner    = IDX_W'(beat.src);
    assign out_addr = beat.addr;
    assign out_data = beat.data;
    assign out_src  = IDX_W'(beat.src);

    // Unpack the flat request buses into per-requester arrays.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[i*CP_IN_ADDR_WIDTH +: CP_IN_ADDR_WIDTH];
            data_arr[i] = req_data[i*CP_DATA_WIDTH +: CP_DATA_WIDTH];
        end
    end

    block_b_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    // Pick burst continuation when allowed, else the round-robin winner.
    always_comb begin
        load         = !out_valid || out_ready;
        cont         = (state == BURST) && req_valid[owner]
                       && (32'(burst_cnt) < MAX_BURST - 1);
        sel_idx      = arb_idx;
        sel_any      = arb_any;
        grant_onehot = arb_grant;
        next_cnt     = '0;
        if (cont) begin
            sel_idx      = owner;
            sel_any      = 1'b1;
            grant_onehot = NUM_REQ'(1) << owner;
            next_cnt     = CNT_W'(32'(burst_cnt) + 1);
        end
        req_ready = (load && !rst) ? grant_onehot : '0;
    end

    // Scheduler state, output beat register, rotation pointer and base registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            ptr       <= '0;
            burst_cnt <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                base[i] <= BASE_WIDTH'(i);
            end
        end else begin
            if (cfg_we && (32'(cfg_idx) < NUM_REQ)) begin
                base[cfg_idx] <= cfg_base;
            end
            if (load && sel_any) begin
                beat.addr <= widen_addr(base[sel_idx], addr_arr[sel_idx]);
                beat.data <= data_arr[sel_idx];
                beat.src  <= SRC_WIDTH'(sel_idx);
                out_valid <= 1'b1;
                busy      <= 1'b1;
                burst_cnt <= next_cnt;
                if (!cont) begin
                    ptr <= IDX_W'((32'(sel_idx) + 1) % NUM_REQ);
                end
                state <= (req_lock[sel_idx] && (32'(next_cnt) < MAX_BURST - 1)) ? BURST : SEND;
            end else if (load) begin
                out_valid <= 1'b0;
                busy      <= 1'b0;
                burst_cnt <= '0;
                state     <= IDLE;
            end
        end
    end

endmodule
